divider_scheduler: RTL and testbench
====================================

# divider_scheduler

Shares one 32-bit multiplication-based divider (32-bit dividend, divisor 1..15) among `num_req_p` requesters. Arbitration is round-robin, with one issue per cycle into a two-stage pipeline. Each requester gets its own response holding slot with valid/ready backpressure. It sits between the core's requester ports and the divider datapath, which it instantiates internally.

## Interface
**Parameters**
- `num_req_p`, default 4: number of requesters (2..8).
- `dividend_width_p`, default 32: dividend/quotient width. Fixed; must match the divider.
- `divisor_width_p`, default 4: divisor and remainder width. Fixed.

**Ports** (clock and reset first)
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `req_valid`  in  `num_req_p`: request present, one bit per requester.
- `req_ready`  out  `num_req_p`: request accepted this cycle (one-hot or zero).
- `req_dividend`  in  `num_req_p` x 32: dividend per requester.
- `req_divisor`  in  `num_req_p` x 4: divisor per requester.
- `rsp_valid`  out  `num_req_p`: response slot full.
- `rsp_ready`  in  `num_req_p`: requester consumes its response.
- `rsp_quotient`  out  `num_req_p` x 32: quotient per slot.
- `rsp_remainder`  out  `num_req_p` x 4: remainder per slot.
- `rsp_err`  out  `num_req_p`: set when divisor was 0.
- `busy`  out  1: any op in S1 or any `rsp_valid` set.

## Operation
- **Eligibility.** Requester i is eligible iff `req_valid[i]`, `!inflight[i]` and `!rsp_valid[i]`. `inflight[i]` = S1 holds id i. At most one outstanding op per requester.
- **Arbitration.** Round-robin from pointer `rr_ptr`, searching i = rr_ptr, rr_ptr+1, … mod `num_req_p`. The first eligible requester is granted.
  - `req_ready` = grant. It is combinational from `req_valid` and registered state.
  - On a grant to g: `rr_ptr <= (g+1) mod num_req_p`. No grant leaves `rr_ptr` unchanged.
- **S0 → S1.** On a handshake, register `s1_valid=1`, `s1_id=g`, dividend and divisor. With no handshake, `s1_valid <= 0`.
- **S1 → slot.** The divider is computed combinationally from the S1 registers. On the next edge, load slot `s1_id`: quotient, remainder, err, and set `rsp_valid[s1_id]=1`.
- **Divisor 0.** Quotient 0, remainder 0, err 1. It still occupies a slot and must be drained.
- **Arithmetic.**
  - Quotient = floor(dividend / divisor); remainder = dividend − quotient·divisor, 4 bits.
  - Divisor 1 passes the dividend through with remainder 0.
- **Drain.** `rsp_valid[i] & rsp_ready[i]` clears `rsp_valid[i]` at the edge. Slot data holds its value until the next load.
- **No same-cycle reissue after drain.** Eligibility uses registered `rsp_valid`, so a requester draining in cycle T is first grantable in T+1.
- **No collisions.** S1 load and slot load never target the same slot at the same time, because eligibility excludes in-flight and full requesters.
- **Reset** (asynchronous, any time) sets:
  - `rsp_valid`, `s1_valid`, `rr_ptr`, `busy` to 0;
  - all slot data, quotient/remainder/err, to 0.
  - In-flight ops are dropped with no response.
- **During reset,** `req_ready` is 0.

## Timing
- Handshake in cycle T. S1 is valid in T+1. `rsp_valid` is high from T+2 until consumed. Fixed latency is 2 cycles.
- Throughput is 1 accepted request per cycle aggregate, and 1 per 3 cycles per requester when `rsp_ready` is held high: accept T, response T+2, drain T+2, reaccept T+3.
- `req_ready` can rise in the same cycle `req_valid` rises. Requesters must hold valid and data stable until the handshake.
- `rsp_valid[i]` stays high until `rsp_ready[i]`. The slot blocks its requester indefinitely under backpressure, and other requesters are unaffected.
- The combinational divider path is S1 register → slot register: one full cycle, no multicycle constraint.
- `busy` is registered-state derived. It is 0 exactly when S1 is empty and all slots are empty.

## Test plan
- **Single request.** Req0: 100 / 7, `rsp_ready=1`. Expect `req_ready[0]` in T; `rsp_valid[0]` in T+2 with q=14, r=2, err=0; `busy` back to 0 at T+3.
- **Large operands.** Req1: 0xFFFFFFFF/3 → q=0x55555555, r=0. Then 1000/13 → q=76, r=12. Then 0xFFFFFFFF/15 → q=0x11111111, r=0. Then divisor 0 → q=0, r=0, err=1.
- **Fairness.** All four requesters valid continuously from reset, `rsp_ready` all 1. Grants go 0, 1, 2, 3 on consecutive cycles, then 0 again at cycle 4. The pattern repeats with no starvation.
- **Backpressure.** Hold `rsp_ready[2]=0` after req2's first response. `req_ready[2]` stays 0 while 0, 1 and 3 keep being granted. Release it: the slot drains, and req2 is grantable the following cycle.
- **Reset mid-operation.** Assert `rst_n=0` with S1 valid and two slots full. All `rsp_valid` drop immediately (asynchronously), and `busy` is 0. After release, the first grant goes to requester 0, and no stale response appears.
- **Exhaustive sweep.** Random dividends × every divisor 0..15 on all ports with random `rsp_ready`. Every response matches the `/` and `%` model, and exactly one response is produced per accepted request.

Source files
------------

// File: rtl/divider_scheduler.sv
// Round-robin scheduler sharing one reciprocal-multiply divider among
// several requesters, with a per-requester response slot.
module divider_scheduler #(
  parameter int num_req_p        = 4,
  parameter int dividend_width_p = 32,
  parameter int divisor_width_p  = 4
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic [num_req_p-1:0]                   req_valid,
  output logic [num_req_p-1:0]                   req_ready,
  input  logic [num_req_p*dividend_width_p-1:0]  req_dividend,
  input  logic [num_req_p*divisor_width_p-1:0]   req_divisor,
  output logic [num_req_p-1:0]                   rsp_valid,
  input  logic [num_req_p-1:0]                   rsp_ready,
  output logic [num_req_p*dividend_width_p-1:0]  rsp_quotient,
  output logic [num_req_p*divisor_width_p-1:0]   rsp_remainder,
  output logic [num_req_p-1:0]                   rsp_err,
  output logic                                   busy
);

  localparam int DW = dividend_width_p;
  localparam int VW = divisor_width_p;
  localparam int IW = (num_req_p > 1) ? $clog2(num_req_p) : 1;
  localparam int RW = DW + VW + 1;
  localparam int PW = DW + DW + VW;

  // floor(2^36 / d); the estimate is low by at most one
  function automatic logic [RW-1:0] recip(input logic [VW-1:0] d);
    case (d)
      4'd1:    recip = 37'h10_0000_0000;
      4'd2:    recip = 37'h08_0000_0000;
      4'd3:    recip = 37'h05_5555_5555;
      4'd4:    recip = 37'h04_0000_0000;
      4'd5:    recip = 37'h03_3333_3333;
      4'd6:    recip = 37'h02_AAAA_AAAA;
      4'd7:    recip = 37'h02_4924_9249;
      4'd8:    recip = 37'h02_0000_0000;
      4'd9:    recip = 37'h01_C71C_71C7;
      4'd10:   recip = 37'h01_9999_9999;
      4'd11:   recip = 37'h01_745D_1745;
      4'd12:   recip = 37'h01_5555_5555;
      4'd13:   recip = 37'h01_3B13_B13B;
      4'd14:   recip = 37'h01_2492_4924;
      4'd15:   recip = 37'h01_1111_1111;
      default: recip = '0;
    endcase
  endfunction

  logic [IW-1:0]        rr_ptr_q, rr_ptr_d;
  logic                 s1_valid_q;
  logic [IW-1:0]        s1_id_q;
  logic [DW-1:0]        s1_dividend_q;
  logic [VW-1:0]        s1_divisor_q;
  logic [num_req_p-1:0] rsp_valid_q;
  logic [DW-1:0]        quot_q [num_req_p];
  logic [VW-1:0]        rem_q  [num_req_p];
  logic [num_req_p-1:0] err_q;

  logic [num_req_p-1:0] inflight;
  logic [num_req_p-1:0] elig;
  logic [num_req_p-1:0] grant;
  logic [IW-1:0]        gnt_id;
  logic                 found;
  logic                 hs;

  logic [DW-1:0] q_est;
  logic [DW-1:0] r_est;
  logic          corr;
  logic [DW-1:0] quot_d;
  logic [VW-1:0] rem_d;
  logic          err_d;

  always_comb begin
    inflight = '0;
    if (s1_valid_q) inflight[s1_id_q] = 1'b1;
  end

  assign elig = req_valid & ~inflight & ~rsp_valid_q;

  always_comb begin
    grant  = '0;
    gnt_id = '0;
    found  = 1'b0;
    for (int k = 0; k < num_req_p; k++) begin
      int idx;
      idx = (int'(rr_ptr_q) + k) % num_req_p;
      if (!found && elig[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        gnt_id     = IW'(idx);
      end
    end
  end

  // no grant may escape while the state is held in reset
  assign req_ready = grant & {num_req_p{rst_n}};
  assign hs        = found & rst_n;

  assign rr_ptr_d = (gnt_id == IW'(num_req_p - 1)) ? '0 : gnt_id + 1'b1;

  always_comb begin
    q_est = DW'((PW'(s1_dividend_q) * PW'(recip(s1_divisor_q))) >> (DW + VW));
    r_est = s1_dividend_q - q_est * DW'(s1_divisor_q);
    corr  = r_est >= DW'(s1_divisor_q);
    if (s1_divisor_q == '0) begin
      quot_d = '0;
      rem_d  = '0;
      err_d  = 1'b1;
    end else begin
      quot_d = q_est + DW'(corr);
      rem_d  = corr ? VW'(r_est - DW'(s1_divisor_q)) : VW'(r_est);
      err_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q      <= '0;
      s1_valid_q    <= 1'b0;
      s1_id_q       <= '0;
      s1_dividend_q <= '0;
      s1_divisor_q  <= '0;
      rsp_valid_q   <= '0;
      err_q         <= '0;
      for (int i = 0; i < num_req_p; i++) begin
        quot_q[i] <= '0;
        rem_q[i]  <= '0;
      end
    end else begin
      s1_valid_q <= hs;
      if (hs) begin
        rr_ptr_q      <= rr_ptr_d;
        s1_id_q       <= gnt_id;
        s1_dividend_q <= req_dividend[gnt_id*DW +: DW];
        s1_divisor_q  <= req_divisor[gnt_id*VW +: VW];
      end
      for (int i = 0; i < num_req_p; i++) begin
        if (s1_valid_q && (s1_id_q == IW'(i))) begin
          quot_q[i]      <= quot_d;
          rem_q[i]       <= rem_d;
          err_q[i]       <= err_d;
          rsp_valid_q[i] <= 1'b1;
        end else if (rsp_valid_q[i] && rsp_ready[i]) begin
          rsp_valid_q[i] <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    rsp_quotient  = '0;
    rsp_remainder = '0;
    for (int i = 0; i < num_req_p; i++) begin
      rsp_quotient[i*DW +: DW]  = quot_q[i];
      rsp_remainder[i*VW +: VW] = rem_q[i];
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = err_q;
  assign busy      = s1_valid_q | (|rsp_valid_q);

endmodule

// File: tb/tb_divider_scheduler.sv
// Scoreboard bench for divider_scheduler: expected results are queued
// at each accepted request and compared when the response is consumed.
module tb_divider_scheduler;

  localparam int NR = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NR-1:0]     req_valid = '0;
  logic [NR-1:0]     req_ready;
  logic [NR*32-1:0]  req_dividend = '0;
  logic [NR*4-1:0]   req_divisor = '0;
  logic [NR-1:0]     rsp_valid;
  logic [NR-1:0]     rsp_ready = '0;
  logic [NR*32-1:0]  rsp_quotient;
  logic [NR*4-1:0]   rsp_remainder;
  logic [NR-1:0]     rsp_err;
  logic              busy;

  divider_scheduler #(.num_req_p(NR)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_dividend(req_dividend), .req_divisor(req_divisor),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_quotient(rsp_quotient), .rsp_remainder(rsp_remainder),
    .rsp_err(rsp_err), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic [31:0] q;
    logic [3:0]  r;
    logic        e;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int acc_cnt = 0;
  int rsp_cnt = 0;

  logic [NR-1:0] auto_en = '0;
  logic          rand_v = 1'b0;
  logic          rand_rdy = 1'b0;
  logic [3:0]    dv_cnt [NR];

  // Requester model: drops valid after a handshake, optionally re-issues
  initial begin
    logic [NR-1:0] hsv;
    for (int i = 0; i < NR; i++) dv_cnt[i] = 4'(i);
    forever begin
      @(negedge clk);
      hsv = req_valid & req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < NR; i++) begin
        if (hsv[i]) req_valid[i] = 1'b0;
        if (!req_valid[i] && auto_en[i] &&
            (!rand_v || $urandom_range(0, 3) != 0)) begin
          req_valid[i] = 1'b1;
          req_dividend[i*32 +: 32] = ($urandom_range(0, 7) == 0) ?
                                     32'hFFFF_FFFF : $urandom;
          req_divisor[i*4 +: 4] = dv_cnt[i];
          dv_cnt[i] = dv_cnt[i] + 4'd1;
        end
        if (rand_rdy) rsp_ready[i] = ($urandom_range(0, 2) != 0);
      end
    end
  end

  // Scoreboard monitor
  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      if ($countones(req_ready) > 1) begin
        errors++;
        $display("FAIL onehot req_ready got %b want at most one bit", req_ready);
      end
      for (int i = 0; i < NR; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          exp_t e;
          logic [31:0] dd;
          logic [3:0]  dv;
          dd = req_dividend[i*32 +: 32];
          dv = req_divisor[i*4 +: 4];
          e.id = i;
          if (dv == 4'd0) begin
            e.q = '0; e.r = '0; e.e = 1'b1;
          end else begin
            e.q = dd / {28'd0, dv};
            e.r = 4'(dd % {28'd0, dv});
            e.e = 1'b0;
          end
          sb.push_back(e);
          acc_cnt++;
        end
      end
      for (int i = 0; i < NR; i++) begin
        if (rsp_valid[i] && rsp_ready[i]) begin
          int k;
          k = -1;
          rsp_cnt++;
          checks++;
          for (int j = 0; j < sb.size(); j++)
            if (k < 0 && sb[j].id == i) k = j;
          if (k < 0) begin
            errors++;
            $display("FAIL stale_rsp%0d got q=%h r=%h e=%b want no response",
                     i, rsp_quotient[i*32 +: 32], rsp_remainder[i*4 +: 4],
                     rsp_err[i]);
          end else begin
            if ({rsp_quotient[i*32 +: 32], rsp_remainder[i*4 +: 4], rsp_err[i]}
                !== {sb[k].q, sb[k].r, sb[k].e}) begin
              errors++;
              $display("FAIL rsp%0d got q=%h r=%h e=%b want q=%h r=%h e=%b",
                       i, rsp_quotient[i*32 +: 32], rsp_remainder[i*4 +: 4],
                       rsp_err[i], sb[k].q, sb[k].r, sb[k].e);
            end
            sb.delete(k);
          end
        end
      end
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic idle(input int n);
    auto_en = '0;
    rand_v = 1'b0;
    rand_rdy = 1'b0;
    rsp_ready = '1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic issue_wait(input int id, input logic [31:0] dd,
                            input logic [3:0] dv);
    bit seen;
    @(posedge clk);
    #1;
    req_dividend[id*32 +: 32] = dd;
    req_divisor[id*4 +: 4] = dv;
    req_valid[id] = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (rsp_valid[id]) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL timeout_req%0d got no response want response", id);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_valid = '1;
    rsp_ready = '1;
    #3;
    checks++;
    if ({req_ready, rsp_valid, busy, rsp_err} !== '0) begin
      errors++;
      $display("FAIL reset_ctl got rdy=%b vld=%b busy=%b err=%b want 0",
               req_ready, rsp_valid, busy, rsp_err);
    end
    checks++;
    if ({rsp_quotient, rsp_remainder} !== '0) begin
      errors++;
      $display("FAIL reset_data got q=%h r=%h want 0",
               rsp_quotient, rsp_remainder);
    end
    req_valid = '0;
    do_reset();
  endtask

  task automatic test_single();
    @(posedge clk);
    #1;
    rsp_ready = '1;
    req_dividend[31:0] = 32'd100;
    req_divisor[3:0] = 4'd7;
    req_valid[0] = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL single_grant got %b want 0001", req_ready);
    end
    @(negedge clk);
    checks++;
    if ({rsp_valid, busy} !== 5'b0000_1) begin
      errors++;
      $display("FAIL single_s1 got vld=%b busy=%b want 0000 1", rsp_valid, busy);
    end
    @(negedge clk);
    checks++;
    if ({rsp_valid, rsp_quotient[31:0], rsp_remainder[3:0], rsp_err[0]} !==
        {4'b0001, 32'd14, 4'd2, 1'b0}) begin
      errors++;
      $display("FAIL single_rsp got vld=%b q=%0d r=%0d e=%b want 0001 14 2 0",
               rsp_valid, rsp_quotient[31:0], rsp_remainder[3:0], rsp_err[0]);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL single_busy got %b want 0", busy);
    end
  endtask

  task automatic test_large();
    logic [31:0] dd [4] = '{32'hFFFF_FFFF, 32'd1000, 32'hFFFF_FFFF, 32'd12345};
    logic [3:0]  dv [4] = '{4'd3, 4'd13, 4'd15, 4'd0};
    logic [31:0] eq [4] = '{32'h5555_5555, 32'd76, 32'h1111_1111, 32'd0};
    logic [3:0]  er [4] = '{4'd0, 4'd12, 4'd0, 4'd0};
    logic        ee [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    rsp_ready = '1;
    for (int k = 0; k < 4; k++) begin
      issue_wait(1, dd[k], dv[k]);
      checks++;
      if ({rsp_quotient[63:32], rsp_remainder[7:4], rsp_err[1]} !==
          {eq[k], er[k], ee[k]}) begin
        errors++;
        $display("FAIL large%0d got q=%h r=%h e=%b want q=%h r=%h e=%b", k,
                 rsp_quotient[63:32], rsp_remainder[7:4], rsp_err[1],
                 eq[k], er[k], ee[k]);
      end
    end
    idle(4);
  endtask

  task automatic test_fairness();
    logic [3:0] exp;
    rsp_ready = '1;
    auto_en = '1;
    do_reset();
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      exp = 4'b0001 << (c % 4);
      checks++;
      if (req_ready !== exp) begin
        errors++;
        $display("FAIL fair_c%0d got %b want %b", c, req_ready, exp);
      end
    end
    idle(8);
  endtask

  task automatic test_backpressure();
    int  gcnt [NR];
    bit  seen;
    rsp_ready = 4'b1011;
    auto_en = '1;
    do_reset();
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (rsp_valid[2]) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL bp_first got no rsp2 want rsp2");
    end
    for (int i = 0; i < NR; i++) gcnt[i] = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      for (int i = 0; i < NR; i++) if (req_ready[i]) gcnt[i]++;
      checks++;
      if ({req_ready[2], rsp_valid[2]} !== 2'b01) begin
        errors++;
        $display("FAIL bp_block got rdy2=%b vld2=%b want 0 1",
                 req_ready[2], rsp_valid[2]);
      end
    end
    checks++;
    if (gcnt[0] < 3 || gcnt[1] < 3 || gcnt[3] < 3) begin
      errors++;
      $display("FAIL bp_others got %0d %0d %0d want >=3 each",
               gcnt[0], gcnt[1], gcnt[3]);
    end
    auto_en = 4'b0100;
    repeat (6) @(posedge clk);
    #1;
    rsp_ready[2] = 1'b1;
    @(negedge clk);
    checks++;
    if ({req_ready[2], rsp_valid[2]} !== 2'b01) begin
      errors++;
      $display("FAIL bp_release got rdy2=%b vld2=%b want 0 1",
               req_ready[2], rsp_valid[2]);
    end
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0100) begin
      errors++;
      $display("FAIL bp_regrant got %b want 0100", req_ready);
    end
    idle(8);
  endtask

  task automatic test_reset_mid();
    rsp_ready = '0;
    auto_en = '1;
    do_reset();
    repeat (4) @(negedge clk);
    checks++;
    if ({rsp_valid, busy} !== 5'b0011_1) begin
      errors++;
      $display("FAIL mid_pre got vld=%b busy=%b want 0011 1", rsp_valid, busy);
    end
    #2;
    rst_n = 1'b0;
    #1;
    sb.delete();
    checks++;
    if ({rsp_valid, busy, req_ready} !== '0) begin
      errors++;
      $display("FAIL mid_async got vld=%b busy=%b rdy=%b want 0",
               rsp_valid, busy, req_ready);
    end
    rsp_ready = '1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL mid_first got %b want 0001", req_ready);
    end
    idle(12);
    checks++;
    if (sb.size() != 0 || rsp_valid !== '0) begin
      errors++;
      $display("FAIL mid_drain got pending=%0d vld=%b want 0 0000",
               sb.size(), rsp_valid);
    end
  endtask

  task automatic test_sweep();
    bit done;
    acc_cnt = 0;
    rsp_cnt = 0;
    rand_v = 1'b1;
    rand_rdy = 1'b1;
    auto_en = '1;
    repeat (1500) @(posedge clk);
    #1;
    auto_en = '0;
    rand_rdy = 1'b0;
    rsp_ready = '1;
    done = 1'b0;
    for (int c = 0; c < 100 && !done; c++) begin
      @(negedge clk);
      if (req_valid == '0 && !busy && sb.size() == 0) done = 1'b1;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL sweep_drain got pending=%0d busy=%b want 0 0",
               sb.size(), busy);
    end
    checks++;
    if (acc_cnt != rsp_cnt || acc_cnt < 500) begin
      errors++;
      $display("FAIL sweep_count got acc=%0d rsp=%0d want equal and >=500",
               acc_cnt, rsp_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_large();
    test_fairness();
    test_backpressure();
    test_reset_mid();
    test_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
